pattern_detector: RTL and testbench

PATTERN_DETECTOR -- requirements
Module: pattern_detector

---
 rtl/pattern_detector_pkg.sv | 17 +
 rtl/pattern_detector_if.sv | 51 +++++
 rtl/pattern_detector_shreg.sv | 44 ++++
 rtl/pattern_detector.sv | 96 +++++++++
 tb/tb_pattern_detector.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pattern_detector_pkg.sv
// rtl/pattern_detector_pkg.sv - shared types and constants for the serial pattern detector
// Contents:
//   state_t      detector FSM states (S_EMPTY, S_FILL, S_ARMED)
//   PAT_LEN_MIN  smallest legal pattern length
//   PAT_LEN_MAX  largest legal pattern length
package pattern_detector_pkg;

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_FILL  = 2'd1,
      S_ARMED = 2'd2
   } state_t;

   localparam int PAT_LEN_MIN = 2;
   localparam int PAT_LEN_MAX = 16;

endpackage

// File: rtl/pattern_detector_if.sv
// rtl/pattern_detector_if.sv - signal bundle between a bit source and the pattern detector
// Optional feature macro: PATDET_COUNT_EN adds the CNT_W parameter and hit_count/hit_clr.
// Signals:
//   x, x_valid   serial data bit and its qualifier
//   pat_load     one-cycle strobe loading pat_in as the new pattern
//   pat_in       new pattern, MSB is the first bit received
//   y            registered match pulse
//   armed        the next valid bit can complete a match
//   hit_count    saturating match count (PATDET_COUNT_EN only)
//   hit_clr      synchronous clear of hit_count (PATDET_COUNT_EN only)
// Modports: master drives stimulus, slave is the detector.
interface pattern_detector_if #(
   parameter int PAT_LEN = 4
`ifdef PATDET_COUNT_EN
   ,
   parameter int CNT_W = 8
`endif
);

   logic               x;
   logic               x_valid;
   logic               pat_load;
   logic [PAT_LEN-1:0] pat_in;
   logic               y;
   logic               armed;
`ifdef PATDET_COUNT_EN
   logic [CNT_W-1:0]   hit_count;
   logic               hit_clr;
`endif

   modport master (
      output x, x_valid, pat_load, pat_in,
      input  y, armed
`ifdef PATDET_COUNT_EN
      ,
      output hit_clr,
      input  hit_count
`endif
   );

   modport slave (
      input  x, x_valid, pat_load, pat_in,
      output y, armed
`ifdef PATDET_COUNT_EN
      ,
      input  hit_clr,
      output hit_count
`endif
   );

endinterface

// File: rtl/pattern_detector_shreg.sv
// rtl/pattern_detector_shreg.sv - bit history and fill counter for the pattern detector
// Ports:
//   clk, reset  clock and asynchronous active-high reset
//   shift       accept x into the history and advance fill
//   clear       restart fill from zero (takes priority over shift for fill)
//   x           incoming serial bit
//   hist        last PAT_LEN-1 accepted bits, newest in bit 0
//   fill        accepted bit count, saturating at PAT_LEN-1
module pattern_detector_shreg #(
   parameter int PAT_LEN = 4,
   parameter int FILL_W  = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               shift,
   input  logic               clear,
   input  logic               x,
   output logic [PAT_LEN-2:0] hist,
   output logic [FILL_W-1:0]  fill
);

   localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_LEN - 1);

   // Widen then truncate so the shift also works for PAT_LEN = 2 (1-bit history).
   logic [PAT_LEN-1:0] hist_wide;
   assign hist_wide = {hist, x};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hist <= '0;
         fill <= '0;
      end else begin
         if (shift) begin
            hist <= hist_wide[PAT_LEN-2:0];
         end
         if (clear) begin
            fill <= '0;
         end else if (shift && (fill != FILL_MAX)) begin
            fill <= fill + FILL_W'(1);
         end
      end
   end

endmodule

// File: rtl/pattern_detector.sv
// rtl/pattern_detector.sv - serial bit-pattern detector with loadable pattern
// Optional feature macro: PATDET_COUNT_EN enables the saturating hit counter.
// Ports:
//   clk    clock, all state changes on the rising edge
//   reset  asynchronous active-high reset
//   bus    pattern_detector_if.slave: x, x_valid, pat_load, pat_in in;
//          y, armed out; hit_clr in / hit_count out with PATDET_COUNT_EN
module pattern_detector
   import pattern_detector_pkg::*;
#(
   parameter int                 PAT_LEN = 4,
   parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
   parameter int                 OVERLAP = 1,
   parameter int                 CNT_W   = 8
) (
   input  logic              clk,
   input  logic              reset,
   pattern_detector_if.slave bus
);

   if ((PAT_LEN < PAT_LEN_MIN) || (PAT_LEN > PAT_LEN_MAX) || (CNT_W < 1)) begin : g_bad_params
      $error("pattern_detector: PAT_LEN or CNT_W out of range");
   end

   localparam int FILL_W = $clog2(PAT_LEN);

   state_t               state;
   logic [PAT_LEN-1:0]   pat_q;
   logic [PAT_LEN-2:0]   hist;
   logic [FILL_W-1:0]    fill;
   logic                 y_q;
   logic                 shift;
   logic                 clear;
   logic                 match;

   // A load in the same cycle discards x, so it also suppresses any match.
   assign shift = bus.x_valid && !bus.pat_load;
   assign match = (state == S_ARMED) && shift && ({hist, bus.x} == pat_q);
   assign clear = bus.pat_load || (match && (OVERLAP == 0));

   pattern_detector_shreg #(
      .PAT_LEN (PAT_LEN),
      .FILL_W  (FILL_W)
   ) u_shreg (
      .clk   (clk),
      .reset (reset),
      .shift (shift),
      .clear (clear),
      .x     (bus.x),
      .hist  (hist),
      .fill  (fill)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_EMPTY;
         pat_q <= PATTERN;
         y_q   <= 1'b0;
      end else begin
         y_q <= match;
         if (bus.pat_load) begin
            pat_q <= bus.pat_in;
            state <= S_EMPTY;
         end else if (bus.x_valid) begin
            case (state)
               S_EMPTY: state <= (PAT_LEN == 2) ? S_ARMED : S_FILL;
               // fill is the pre-increment count, so PAT_LEN-2 means this bit arms us.
               S_FILL:  if (fill == FILL_W'(PAT_LEN - 2)) state <= S_ARMED;
               S_ARMED: if (match && (OVERLAP == 0)) state <= S_EMPTY;
               default: state <= S_EMPTY;
            endcase
         end
      end
   end

   assign bus.y     = y_q;
   assign bus.armed = (state == S_ARMED);

`ifdef PATDET_COUNT_EN
   logic [CNT_W-1:0] cnt_q;

   // Clear beats a coincident match.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else if (bus.hit_clr) begin
         cnt_q <= '0;
      end else if (match && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign bus.hit_count = cnt_q;
`endif

endmodule

// File: tb/tb_pattern_detector.sv
// tb/tb_pattern_detector.sv - self-checking bench for pattern_detector (overlap and non-overlap)
module tb_pattern_detector;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

`ifdef PATDET_COUNT_EN
   pattern_detector_if #(.PAT_LEN(4), .CNT_W(2)) ifo ();
   pattern_detector_if #(.PAT_LEN(4), .CNT_W(8)) ifn ();
`else
   pattern_detector_if #(.PAT_LEN(4)) ifo ();
   pattern_detector_if #(.PAT_LEN(4)) ifn ();
`endif

   pattern_detector #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1), .CNT_W(2)) dut_o (
      .clk(clk), .reset(reset), .bus(ifo));
   pattern_detector #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(0), .CNT_W(8)) dut_n (
      .clk(clk), .reset(reset), .bus(ifn));

   int n_cmp = 0;
   int n_fail = 0;

   // Reference model: bits received since the last restart, current pattern, hit count.
   bit         q_o[$];
   bit         q_n[$];
   logic [3:0] pat = 4'b1011;
   int         cnt = 0;
   int         pulses_o = 0;
   int         pulses_n = 0;

   function automatic bit window_hit(input bit q[$], input logic [3:0] p);
      logic [3:0] w;
      if (q.size() < 4) return 1'b0;
      for (int i = 0; i < 4; i++) w[3-i] = q[q.size() - 4 + i];
      return w == p;
   endfunction

   task automatic step(input bit v, input bit xb, input bit ld, input logic [3:0] pin, input bit clr);
      bit mo, mn;
      ifo.x = xb; ifo.x_valid = v; ifo.pat_load = ld; ifo.pat_in = pin;
      ifn.x = xb; ifn.x_valid = v; ifn.pat_load = ld; ifn.pat_in = pin;
`ifdef PATDET_COUNT_EN
      ifo.hit_clr = clr; ifn.hit_clr = clr;
`endif
      @(posedge clk);
      #1;
      mo = 1'b0;
      mn = 1'b0;
      if (ld) begin
         pat = pin;
         q_o.delete();
         q_n.delete();
      end else if (v) begin
         q_o.push_back(xb);
         q_n.push_back(xb);
         mo = window_hit(q_o, pat);
         mn = window_hit(q_n, pat);
         if (mn) q_n.delete();
         while (q_o.size() > 3) void'(q_o.pop_front());
         while (q_n.size() > 3) void'(q_n.pop_front());
      end
      if (clr) cnt = 0;
      else if (mo && cnt < 3) cnt++;
      pulses_o += int'(ifo.y);
      pulses_n += int'(ifn.y);

      n_cmp++;
      if (ifo.y !== mo) begin
         n_fail++;
         $display("FAIL y_overlap t=%0t got %b expected %b", $time, ifo.y, mo);
      end
      n_cmp++;
      if (ifn.y !== mn) begin
         n_fail++;
         $display("FAIL y_nonoverlap t=%0t got %b expected %b", $time, ifn.y, mn);
      end
      n_cmp++;
      if (ifo.armed !== (q_o.size() >= 3)) begin
         n_fail++;
         $display("FAIL armed_overlap t=%0t got %b expected %b", $time, ifo.armed, q_o.size() >= 3);
      end
      n_cmp++;
      if (ifn.armed !== (q_n.size() >= 3)) begin
         n_fail++;
         $display("FAIL armed_nonoverlap t=%0t got %b expected %b", $time, ifn.armed, q_n.size() >= 3);
      end
`ifdef PATDET_COUNT_EN
      n_cmp++;
      if (ifo.hit_count !== 2'(cnt)) begin
         n_fail++;
         $display("FAIL hit_count t=%0t got %0d expected %0d", $time, ifo.hit_count, cnt);
      end
`endif
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
   endtask

   task automatic bits(input logic [3:0] b, input int n);
      for (int i = n - 1; i >= 0; i--) step(1'b1, b[i], 1'b0, 4'b0000, 1'b0);
   endtask

   task automatic check_pulses(input string name, input int exp_o, input int exp_n);
      n_cmp++;
      if (pulses_o !== exp_o) begin
         n_fail++;
         $display("FAIL %s_pulses_overlap got %0d expected %0d", name, pulses_o, exp_o);
      end
      n_cmp++;
      if (pulses_n !== exp_n) begin
         n_fail++;
         $display("FAIL %s_pulses_nonoverlap got %0d expected %0d", name, pulses_n, exp_n);
      end
      pulses_o = 0;
      pulses_n = 0;
   endtask

   // Asynchronous reset pulse placed between clock edges; outputs must drop at once.
   task automatic pulse_reset();
      reset = 1'b1;
      #2;
      n_cmp++;
      if (ifo.y !== 1'b0 || ifn.y !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset_y got %b/%b expected 0/0", ifo.y, ifn.y);
      end
      n_cmp++;
      if (ifo.armed !== 1'b0 || ifn.armed !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset_armed got %b/%b expected 0/0", ifo.armed, ifn.armed);
      end
`ifdef PATDET_COUNT_EN
      n_cmp++;
      if (ifo.hit_count !== 2'd0) begin
         n_fail++;
         $display("FAIL async_reset_count got %0d expected 0", ifo.hit_count);
      end
`endif
      q_o.delete();
      q_n.delete();
      pat = 4'b1011;
      cnt = 0;
      #2;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      ifo.x = 1'b0; ifo.x_valid = 1'b0; ifo.pat_load = 1'b0; ifo.pat_in = 4'b0000;
      ifn.x = 1'b0; ifn.x_valid = 1'b0; ifn.pat_load = 1'b0; ifn.pat_in = 4'b0000;
`ifdef PATDET_COUNT_EN
      ifo.hit_clr = 1'b0; ifn.hit_clr = 1'b0;
`endif
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if (ifo.y !== 1'b0 || ifn.y !== 1'b0 || ifo.armed !== 1'b0 || ifn.armed !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_outputs got y=%b/%b armed=%b/%b expected all 0",
                  ifo.y, ifn.y, ifo.armed, ifn.armed);
      end
      reset = 1'b0;
      idle(2);
   endtask

   task automatic test_basic();
      bits(4'b1011, 4);
      idle(3);
      check_pulses("basic", 1, 1);
   endtask

   task automatic test_all_ones();
      step(1'b0, 1'b0, 1'b1, 4'b1111, 1'b0);
      for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 4'b0000, 1'b0);
      idle(2);
      check_pulses("all_ones", 3, 1);
   endtask

   task automatic test_gaps();
      logic [3:0] b = 4'b1011;
      step(1'b0, 1'b0, 1'b1, 4'b1011, 1'b0);
      for (int i = 3; i >= 0; i--) begin
         idle(int'($urandom_range(1, 3)));
         step(1'b1, b[i], 1'b0, 4'b0000, 1'b0);
      end
      idle(3);
      check_pulses("gaps", 1, 1);
   endtask

   task automatic test_load_mid();
      bits(4'b0010, 2);
      step(1'b1, 1'b1, 1'b1, 4'b0110, 1'b0);
      bits(4'b0110, 4);
      idle(2);
      check_pulses("load_mid", 1, 1);
   endtask

   task automatic test_reset_mid();
      step(1'b0, 1'b0, 1'b1, 4'b1011, 1'b0);
      bits(4'b0101, 3);
      pulse_reset();
      bits(4'b0001, 1);
      idle(2);
      check_pulses("reset_mid", 0, 0);
   endtask

`ifdef PATDET_COUNT_EN
   task automatic test_count();
      step(1'b0, 1'b0, 1'b1, 4'b1011, 1'b1);
      for (int i = 0; i < 5; i++) bits(4'b1011, 4);
      n_cmp++;
      if (ifo.hit_count !== 2'd3) begin
         n_fail++;
         $display("FAIL count_saturate got %0d expected 3", ifo.hit_count);
      end
      bits(4'b0101, 3);
      step(1'b1, 1'b1, 1'b0, 4'b0000, 1'b1);
      n_cmp++;
      if (ifo.hit_count !== 2'd0) begin
         n_fail++;
         $display("FAIL count_clear_wins got %0d expected 0", ifo.hit_count);
      end
      idle(2);
      pulses_o = 0;
      pulses_n = 0;
   endtask
`endif

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         int r = int'($urandom_range(0, 24));
         logic [3:0] pin = 4'($urandom);
         if (r == 0) pin = 4'b0000;
         if (r == 1) pin = 4'b1111;
         step($urandom_range(0, 3) != 0, 1'($urandom), r < 3, pin, r == 3);
      end
      idle(2);
      pulses_o = 0;
      pulses_n = 0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_all_ones();
      test_gaps();
      test_load_mid();
      test_reset_mid();
`ifdef PATDET_COUNT_EN
      test_count();
`endif
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
